// File: rtl/unidad_control_mc.sv
// Multicycle control unit: decodes the 6-bit opcode into datapath controls,
// sequences the two-cycle load, holds in HALT and counts retired instructions.
module unidad_control_mc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    output logic             s_inc,
    output logic             selectorMuxSaltoR,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             activarMemoria,
    output logic             guardarMemoriaDatos,
    output logic             selecionarMuxDireccionesMemoriaDatos,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOAD_WB = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg;
    logic             retire;
    logic             undefined;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= RUN;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                count_reg <= count_reg + ONE;
            end
            if (undefined) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        s_inc                                = 1'b1;
        selectorMuxSaltoR                    = 1'b0;
        s_inm                                = 1'b0;
        we3                                  = 1'b0;
        wez                                  = 1'b0;
        op_alu                               = 3'b000;
        activarMemoria                       = 1'b0;
        guardarMemoriaDatos                  = 1'b0;
        selecionarMuxDireccionesMemoriaDatos = 1'b0;
        pc_we                                = 1'b1;
        halted                               = 1'b0;
        retire                               = 1'b0;
        undefined                            = 1'b0;
        state_next                           = state_reg;

        case (state_reg)
            RUN: begin
                retire = 1'b1;
                casez (opcode)
                    6'b000???: begin
                        op_alu = opcode[2:0];
                        we3    = 1'b1;
                        wez    = 1'b1;
                    end
                    6'b0100??: begin
                        s_inm = 1'b1;
                        we3   = 1'b1;
                    end
                    6'b010100: s_inc = 1'b0;
                    6'b010101: s_inc = ~z;
                    6'b010110: s_inc = z;
                    6'b010111: selectorMuxSaltoR = 1'b1;
                    6'b1001??: begin
                        activarMemoria      = 1'b1;
                        guardarMemoriaDatos = 1'b1;
                    end
                    6'b10000?: begin
                        // First load cycle: PC stalls so the opcode stays put for write-back.
                        activarMemoria                       = 1'b1;
                        selecionarMuxDireccionesMemoriaDatos = 1'b1;
                        pc_we                                = 1'b0;
                        retire                               = 1'b0;
                        state_next                           = LOAD_WB;
                    end
                    6'b110000: begin
                        retire = 1'b1;
                    end
                    6'b111111: begin
                        pc_we      = 1'b0;
                        retire     = 1'b0;
                        state_next = HALT;
                    end
                    default: undefined = 1'b1;
                endcase
            end
            LOAD_WB: begin
                activarMemoria                       = 1'b1;
                selecionarMuxDireccionesMemoriaDatos = 1'b1;
                we3                                  = 1'b1;
                retire                               = 1'b1;
                state_next                           = RUN;
            end
            HALT: begin
                pc_we  = 1'b0;
                halted = 1'b1;
            end
            default: state_next = RUN;
        endcase

        // During reset no architectural state may change, but the PC must load its own reset.
        if (!reset) begin
            we3                 = 1'b0;
            wez                 = 1'b0;
            activarMemoria      = 1'b0;
            guardarMemoriaDatos = 1'b0;
            pc_we               = 1'b1;
        end
    end

    assign illegal     = illegal_reg;
    assign instr_count = count_reg;

endmodule

// File: doc/unidad_control_mc.md
UNIDAD_CONTROL_MC -- requirements
Module: unidad_control_mc

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 Reset: one clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  system clock, rising edge.
REQ-004 Port: reset  input  1  synchronous reset, active-low (0 = reset).
REQ-005 Port: opcode  input  6  instruction bits [15:10] from program memory.
REQ-006 Port: z  input  1  registered zero flag from the datapath.
REQ-007 Port: s_inc  output  1  PC mux select (1 = PC+offset, 0 = absolute address [9:0]).
REQ-008 Port: selectorMuxSaltoR  output  1  offset select (0 = +1, 1 = relative [9:0]).
REQ-009 Port: s_inm  output  1  register write-data select (1 = immediate [11:4]).
REQ-010 Port: we3  output  1  register file write enable.
REQ-011 Port: wez  output  1  zero flag load enable.
REQ-012 Port: op_alu  output  3  ALU operation.
REQ-013 Port: activarMemoria  output  1  data memory enable.
REQ-014 Port: guardarMemoriaDatos  output  1  data memory write.
REQ-015 Port: selecionarMuxDireccionesMemoriaDatos  output  1  address select (0 = [6:0], 1 = [10:4]).
REQ-016 Port: pc_we  output  1  PC load enable (0 = stall).
REQ-017 Port: halted  output  1  high in HALT state.
REQ-018 Port: illegal  output  1  sticky, set by an undefined opcode.
REQ-019 Port: instr_count  output  CNT_W  retired-instruction count.

Function
REQ-020 States: RUN, LOAD_WB, HALT. Outputs are combinational from state, opcode and z. Unlisted outputs are 0, except s_inc=1 and pc_we=1.
REQ-021 ALU, opcode[5:3]=000: op_alu=opcode[2:0], we3=1, wez=1. Retires in 1 cycle.
REQ-022 LI, opcode[5:2]=0100: s_inm=1, we3=1. Retires in 1 cycle.
REQ-023 J, 010100: s_inc=0.
REQ-024 JZ, 010101: s_inc=~z.
REQ-025 JNZ, 010110: s_inc=z.
REQ-026 JR, 010111: selectorMuxSaltoR=1. PC wraps modulo 1024.
REQ-027 ST, opcode[5:2]=1001: activarMemoria=1, guardarMemoriaDatos=1, address select 0. Retires in 1 cycle.
REQ-028 LD, opcode[5:1]=10000, RUN cycle: activarMemoria=1, address select 1, we3=0, pc_we=0. Next state LOAD_WB.
REQ-029 LD, LOAD_WB cycle: activarMemoria=1, address select 1, we3=1, pc_we=1. Next state RUN. LD retires after 2 cycles.
REQ-030 NOP, 110000: no writes.
REQ-031 HALT, 111111: pc_we=0. Next state HALT.
REQ-032 In HALT: pc_we=0, all write and memory enables 0, halted=1. Only reset leaves HALT.
REQ-033 Undefined opcode: executes as NOP, sets illegal at the next edge, and retires.
REQ-034 instr_count increments by 1 on each retiring edge: non-LD in RUN, and LOAD_WB. It does not increment in the LD first cycle, in HALT, or on the HALT-entry edge. It wraps from all-ones to 0.
REQ-035 No opcode is sampled in LOAD_WB. The LD opcode is held because pc_we was 0.

Reset
REQ-036 While reset=0: we3, wez, activarMemoria, guardarMemoriaDatos are forced to 0, and pc_we=1 so the PC register takes its own reset.
REQ-037 At a clk edge with reset=0: state=RUN, instr_count=0, illegal=0. This overrides any state, including LOAD_WB and HALT.

Verification
REQ-038 opcode=000011, z=x -> op_alu=011, we3=1, wez=1, s_inc=1, pc_we=1; instr_count increments by 1.
REQ-039 LD opcode=100000 -> cycle 1: pc_we=0, we3=0, activarMemoria=1, sel=1. Cycle 2: we3=1, pc_we=1. instr_count +1 after 2 edges.
REQ-040 JZ with z=1 -> s_inc=0. JZ with z=0 -> s_inc=1. JNZ gives the inverse in each case.
REQ-041 HALT (111111), then opcode changed to 000000 -> halted=1, pc_we=0, we3=0, count frozen for 10 cycles. Then reset=0 for 1 edge -> RUN, count=0.
REQ-042 Reset asserted during LOAD_WB -> next state RUN, we3=0 while reset is low, instr_count=0.
REQ-043 Opcode 111000 -> illegal=1 after 1 edge and stays 1 through later legal opcodes. Preload instr_count to FFFF with CNT_W=16 -> next retirement gives 0000.
